// File: rtl/shifter_pkg.sv
// Shared definitions for the operand-2 shifter front end: shift codes, FSM states,
// instruction field positions and the decoded-field bundle.
package shifter_pkg;

  typedef enum logic [1:0] {
    ShLsl = 2'b00,
    ShLsr = 2'b01,
    ShAsr = 2'b10,
    ShRor = 2'b11
  } shift_type_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRdRm = 2'b01,
    StRdRs = 2'b10,
    StOut  = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    FormRotImm,
    FormImmSh,
    FormRegSh,
    FormErr
  } form_e;

  // Instruction bit positions (LSB of each multi-bit field)
  localparam int unsigned InstI         = 25;
  localparam int unsigned InstShReg     = 4;
  localparam int unsigned InstMulBit    = 7;
  localparam int unsigned InstShTypeLsb = 5;
  localparam int unsigned InstRmLsb     = 0;
  localparam int unsigned InstRsLsb     = 8;
  localparam int unsigned InstShamtLsb  = 7;
  localparam int unsigned InstRotLsb    = 8;
  localparam int unsigned InstImm8Lsb   = 0;

  localparam logic [31:0] PcOfsImmDefault = 32'd8;
  localparam logic [31:0] PcOfsRegDefault = 32'd12;

  typedef struct packed {
    form_e       form;
    logic [3:0]  rm;
    logic [3:0]  rs;
    logic [7:0]  imm_amt;
    logic [2:0]  shift_op;
    logic [31:0] imm_data;
  } op2_dec_t;

endpackage

// File: rtl/op2_field_decode.sv
// Combinational decode of a data-processing word into its operand-2 form and fields.
module op2_field_decode
  import shifter_pkg::*;
(
  input  logic [31:0] inst_i,
  output op2_dec_t    dec_o
);

  logic [1:0] sh_type;
  logic       unused_inst;

  assign sh_type     = inst_i[InstShTypeLsb +: 2];
  assign unused_inst = ^{inst_i[31:26], inst_i[24:12]};

  always_comb begin
    dec_o          = '0;
    dec_o.rm       = inst_i[InstRmLsb +: 4];
    dec_o.rs       = inst_i[InstRsLsb +: 4];
    if (inst_i[InstI]) begin
      dec_o.form     = FormRotImm;
      dec_o.imm_data = {24'd0, inst_i[InstImm8Lsb +: 8]};
      dec_o.imm_amt  = {3'd0, inst_i[InstRotLsb +: 4], 1'b0};
      dec_o.shift_op = {ShRor, 1'b1};
    end else if (!inst_i[InstShReg]) begin
      dec_o.form     = FormImmSh;
      dec_o.imm_amt  = {3'd0, inst_i[InstShamtLsb +: 5]};
      dec_o.shift_op = {sh_type, 1'b0};
    end else if (!inst_i[InstMulBit]) begin
      dec_o.form     = FormRegSh;
      dec_o.shift_op = {sh_type, 1'b1};
    end else begin
      // Multiply/extension space: all data fields stay zero
      dec_o.form     = FormErr;
    end
  end

endmodule

// File: rtl/op2_shift_ctrl.sv
// Operand-2 front end: fetches Rm/Rs through one RF read port and presents a registered
// shifter command (data, amount, op, carry) behind a valid/ready handshake.
module op2_shift_ctrl
  import shifter_pkg::*;
#(
  parameter logic [31:0] PC_OFS_IMM = PcOfsImmDefault,
  parameter logic [31:0] PC_OFS_REG = PcOfsRegDefault
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic        Carry_flag_in,
  input  logic [31:0] pc_in,
  output logic [3:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  output logic [31:0] Shift_Data,
  output logic [7:0]  Shift_Num,
  output logic [2:0]  SHIFT_OP,
  output logic        Carry_flag,
  output logic        out_err,
  output logic        out_valid,
  input  logic        out_ready
);

  state_e      state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] shift_data_q, shift_data_d;
  logic [7:0]  shift_num_q, shift_num_d;
  logic [2:0]  shift_op_q, shift_op_d;
  logic        carry_q, carry_d;
  logic        err_q, err_d;
  logic [3:0]  raddr_q, raddr_d;

  op2_dec_t    dec;
  logic [31:0] dec_inst;
  logic [31:0] pc_ofs;
  logic [31:0] rd_val;

  // Decode the live word while idle, the latched word afterwards
  assign dec_inst = (state_q == StIdle) ? inst : inst_q;

  op2_field_decode u_decode (
    .inst_i (dec_inst),
    .dec_o  (dec)
  );

  assign pc_ofs = (dec.form == FormImmSh) ? PC_OFS_IMM : PC_OFS_REG;
  assign rd_val = (raddr_q == 4'hf) ? (pc_q + pc_ofs) : rf_rdata;

  always_comb begin
    state_d      = state_q;
    inst_d       = inst_q;
    pc_d         = pc_q;
    shift_data_d = shift_data_q;
    shift_num_d  = shift_num_q;
    shift_op_d   = shift_op_q;
    carry_d      = carry_q;
    err_d        = err_q;
    raddr_d      = raddr_q;
    unique case (state_q)
      StIdle: begin
        if (inst_valid) begin
          inst_d       = inst;
          pc_d         = pc_in;
          carry_d      = Carry_flag_in;
          shift_data_d = dec.imm_data;
          shift_num_d  = dec.imm_amt;
          shift_op_d   = dec.shift_op;
          err_d        = (dec.form == FormErr);
          if (dec.form == FormRotImm || dec.form == FormErr) begin
            state_d = StOut;
          end else begin
            state_d = StRdRm;
            raddr_d = dec.rm;
          end
        end
      end
      StRdRm: begin
        shift_data_d = rd_val;
        if (dec.form == FormRegSh) begin
          raddr_d = dec.rs;
          state_d = StRdRs;
        end else begin
          state_d = StOut;
        end
      end
      StRdRs: begin
        // Only Rs[7:0] matters; larger amounts reach the shifter unchanged
        shift_num_d = rd_val[7:0];
        state_d     = StOut;
      end
      StOut: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      inst_q       <= '0;
      pc_q         <= '0;
      shift_data_q <= '0;
      shift_num_q  <= '0;
      shift_op_q   <= '0;
      carry_q      <= 1'b0;
      err_q        <= 1'b0;
      raddr_q      <= '0;
    end else begin
      state_q      <= state_d;
      inst_q       <= inst_d;
      pc_q         <= pc_d;
      shift_data_q <= shift_data_d;
      shift_num_q  <= shift_num_d;
      shift_op_q   <= shift_op_d;
      carry_q      <= carry_d;
      err_q        <= err_d;
      raddr_q      <= raddr_d;
    end
  end

  assign inst_ready = (state_q == StIdle);
  assign out_valid  = (state_q == StOut);
  assign rf_raddr   = raddr_q;
  assign Shift_Data = shift_data_q;
  assign Shift_Num  = shift_num_q;
  assign SHIFT_OP   = shift_op_q;
  assign Carry_flag = carry_q;
  assign out_err    = err_q;

endmodule

// File: tb/tb_op2_shift_ctrl.sv
// Bench for op2_shift_ctrl: directed and random instructions checked against an
// arithmetic model of the operand-2 forms, with a register file behind the read port.
module tb_op2_shift_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst = '0;
  logic        inst_valid = 1'b0;
  logic        inst_ready;
  logic        Carry_flag_in = 1'b0;
  logic [31:0] pc_in = '0;
  logic [3:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic [31:0] Shift_Data;
  logic [7:0]  Shift_Num;
  logic [2:0]  SHIFT_OP;
  logic        Carry_flag;
  logic        out_err;
  logic        out_valid;
  logic        out_ready = 1'b0;

  logic [31:0] regs [16];
  logic [3:0]  last_raddr;
  int          checks = 0;
  int          errors = 0;

  assign rf_rdata = regs[rf_raddr];

  always #5 clk = ~clk;

  op2_shift_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .inst          (inst),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .Carry_flag_in (Carry_flag_in),
    .pc_in         (pc_in),
    .rf_raddr      (rf_raddr),
    .rf_rdata      (rf_rdata),
    .Shift_Data    (Shift_Data),
    .Shift_Num     (Shift_Num),
    .SHIFT_OP      (SHIFT_OP),
    .Carry_flag    (Carry_flag),
    .out_err       (out_err),
    .out_valid     (out_valid),
    .out_ready     (out_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] opnd(input logic [3:0] r, input logic [31:0] pc,
                                       input logic [31:0] ofs);
    return (r == 4'hf) ? pc + ofs : regs[r];
  endfunction

  // Expected shifter command, number of RF reads and their addresses
  task automatic model(input logic [31:0] i, input logic [31:0] pc,
                       output logic [31:0] d, output logic [7:0] n, output logic [2:0] op,
                       output logic err, output int nrd,
                       output logic [3:0] a0, output logic [3:0] a1);
    logic [31:0] rs_val;
    d = '0; n = '0; op = '0; err = 1'b0; nrd = 0;
    a0 = i[3:0];
    a1 = i[11:8];
    if (i[25]) begin
      d  = {24'd0, i[7:0]};
      n  = 8'(i[11:8]) * 8'd2;
      op = 3'b111;
    end else if (!i[4]) begin
      nrd = 1;
      d   = opnd(i[3:0], pc, 32'd8);
      n   = 8'(i[11:7]);
      op  = {i[6:5], 1'b0};
    end else if (!i[7]) begin
      nrd    = 2;
      d      = opnd(i[3:0], pc, 32'd12);
      rs_val = opnd(i[11:8], pc, 32'd12);
      n      = rs_val[7:0];
      op     = {i[6:5], 1'b1};
    end else begin
      err = 1'b1;
    end
  endtask

  task automatic run_op(input logic [31:0] i, input logic c, input logic [31:0] pc,
                        input int stall);
    logic [31:0] e_data;
    logic [7:0]  e_num;
    logic [2:0]  e_op;
    logic        e_err;
    int          nrd;
    int          lat;
    logic [3:0]  ea0, ea1;
    logic [3:0]  oa0, oa1;
    logic [46:0] snap;
    model(i, pc, e_data, e_num, e_op, e_err, nrd, ea0, ea1);
    check("inst_ready_idle", 64'(inst_ready), 64'd1);
    inst = i; Carry_flag_in = c; pc_in = pc; inst_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    // Scramble inputs after accept so only latched values can reach the outputs
    inst_valid = 1'b0; inst = $urandom; Carry_flag_in = ~c; pc_in = $urandom;
    lat = 1; oa0 = 'x; oa1 = 'x;
    while (!out_valid && lat < 8) begin
      if (lat == 1) oa0 = rf_raddr;
      if (lat == 2) oa1 = rf_raddr;
      lat++;
      @(negedge clk);
    end
    check("latency", 64'(lat), 64'(nrd + 1));
    if (nrd >= 1) check("raddr_rm", 64'(oa0), 64'(ea0));
    if (nrd == 2) check("raddr_rs", 64'(oa1), 64'(ea1));
    if (nrd == 1) last_raddr = ea0;
    if (nrd == 2) last_raddr = ea1;
    check("shift_data", 64'(Shift_Data), 64'(e_data));
    check("shift_num", 64'(Shift_Num), 64'(e_num));
    check("shift_op", 64'(SHIFT_OP), 64'(e_op));
    check("out_err", 64'(out_err), 64'(e_err));
    if (!e_err) check("carry", 64'(Carry_flag), 64'(c));
    check("raddr_hold", 64'(rf_raddr), 64'(last_raddr));
    check("inst_ready_busy", 64'(inst_ready), 64'd0);
    snap = {Shift_Data, Shift_Num, SHIFT_OP, Carry_flag, out_err, out_valid, inst_ready};
    for (int s = 0; s < stall; s++) begin
      inst_valid = 1'b1; inst = $urandom;
      @(negedge clk);
      check("stall_stable", 64'({Shift_Data, Shift_Num, SHIFT_OP, Carry_flag, out_err,
                                 out_valid, inst_ready}), 64'(snap));
    end
    inst_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_drop", 64'(out_valid), 64'd0);
    check("ready_back", 64'(inst_ready), 64'd1);
  endtask

  initial begin
    for (int r = 0; r < 16; r++) regs[r] = $urandom;
    regs[1] = 32'hDEADBEEF;
    regs[2] = 32'h12345678;
    regs[3] = 32'hFFFFFF20;
    last_raddr = 4'd0;

    #2;
    check("rst_data", 64'(Shift_Data), 64'd0);
    check("rst_num_op", 64'({Shift_Num, SHIFT_OP}), 64'd0);
    check("rst_flags", 64'({Carry_flag, out_err, out_valid}), 64'd0);
    check("rst_raddr", 64'(rf_raddr), 64'd0);
    check("rst_ready", 64'(inst_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(32'hE3A004FF, 1'b1, 32'h0000_0100, 0);
    run_op(32'hE0810182, 1'b0, 32'h0000_0200, 4);
    run_op(32'hE1A00371, 1'b1, 32'h0000_0300, 1);
    run_op(32'hE081018F, 1'b0, 32'h0000_1000, 0);
    run_op(32'hE1A0037F, 1'b1, 32'h0000_1000, 0);
    run_op(32'hE1A00F11, 1'b0, 32'h0001_2345, 0);
    run_op(32'hE0000091, 1'b1, 32'h0000_0400, 2);
    run_op(32'hE1A0F070, 1'b1, 32'hFFFF_FFF8, 0);

    // Abort a register-shift operation in RD_RS
    inst = 32'hE1A00371; inst_valid = 1'b1;
    @(negedge clk);
    inst_valid = 1'b0;
    @(negedge clk);
    check("abort_rs_addr", 64'(rf_raddr), 64'd3);
    rst_n = 1'b0;
    #1;
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_data", 64'(Shift_Data), 64'd0);
    check("abort_num_op", 64'({Shift_Num, SHIFT_OP}), 64'd0);
    check("abort_flags", 64'({Carry_flag, out_err}), 64'd0);
    check("abort_raddr", 64'(rf_raddr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_raddr = 4'd0;
    @(negedge clk);
    check("abort_ready", 64'(inst_ready), 64'd1);
    check("abort_novalid", 64'(out_valid), 64'd0);

    for (int k = 0; k < 30; k++) begin
      logic [31:0] ri;
      for (int r = 0; r < 16; r++) regs[r] = $urandom;
      ri = $urandom;
      if ($urandom_range(0, 3) == 0) ri[3:0] = 4'hf;
      if ($urandom_range(0, 3) == 0) ri[11:8] = 4'hf;
      run_op(ri, 1'($urandom), $urandom, int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
